// File: rtl/fp16_acc_seq.sv
// Sequential FP16 packet accumulator driving an external pipelined adder.
// One element is in flight at a time: operands are held while the adder result ripples through.
module fp16_acc_seq #(
  parameter int ADD_LAT = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  input  logic             in_mode,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  output logic             add_mode,
  input  logic [15:0]      add_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [CNT_W-1:0] out_count
);

  localparam int LAT_W = $clog2(ADD_LAT + 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OUT} state_t;

  state_t           r_state;
  logic [LAT_W-1:0] r_lat;
  logic [15:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_add_b;
  logic             r_add_mode;
  logic             r_last;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [15:0]      r_out_data;
  logic [CNT_W-1:0] r_out_count;

  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_inc;

  // r_in_ready mirrors IDLE, but stays low for the first cycle after reset release
  assign w_accept  = r_in_ready & in_valid;
  assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  assign in_ready  = r_in_ready;
  assign add_a     = r_acc;
  assign add_b     = r_add_b;
  assign add_mode  = r_add_mode;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_lat       <= '0;
      r_acc       <= 16'h0000;
      r_cnt       <= '0;
      r_add_b     <= 16'h0000;
      r_add_mode  <= 1'b0;
      r_last      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 16'h0000;
      r_out_count <= '0;
    end else if (clr) begin
      r_state     <= S_IDLE;
      r_lat       <= '0;
      r_acc       <= 16'h0000;
      r_cnt       <= '0;
      r_add_b     <= 16'h0000;
      r_add_mode  <= 1'b0;
      r_last      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= 16'h0000;
      r_out_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_add_b    <= in_data;
            r_last     <= in_last;
            if (r_cnt == '0) r_add_mode <= in_mode;
            r_lat      <= LAT_W'(ADD_LAT);
            r_in_ready <= 1'b0;
            r_state    <= S_WAIT;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_WAIT: begin
          // lat reaches zero on the edge ADD_LAT+1 after accept; add_res is settled then
          if (r_lat == '0) begin
            r_acc <= add_res;
            r_cnt <= w_cnt_inc;
            if (r_last) begin
              r_state     <= S_OUT;
              r_out_valid <= 1'b1;
              r_out_data  <= add_res;
              r_out_count <= w_cnt_inc;
            end else begin
              r_state    <= S_IDLE;
              r_in_ready <= 1'b1;
            end
          end else begin
            r_lat <= r_lat - LAT_W'(1);
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_acc       <= 16'h0000;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= 16'h0000;
            r_out_count <= '0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_acc_seq.sv
// Bench for fp16_acc_seq: behavioural pipelined FP16 adder plus a real-valued packet-sum model.
module tb_fp16_acc_seq;
  localparam int ADD_LAT = 2;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             in_last;
  logic             in_mode;
  logic [15:0]      add_a;
  logic [15:0]      add_b;
  logic             add_mode;
  logic [15:0]      add_res;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_data;
  logic [CNT_W-1:0] out_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc_cyc;
  int ov_cyc;

  logic        force_en = 1'b0;
  logic [15:0] force_val = 16'h0000;
  logic [15:0] pipe [ADD_LAT];

  fp16_acc_seq #(.ADD_LAT(ADD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_mode(in_mode),
    .add_a(add_a), .add_b(add_b), .add_mode(add_mode), .add_res(add_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real h2r(input logic [15:0] h);
    real v;
    int  p;
    v = real'(h[9:0]);
    p = int'(h[14:10]);
    if (p != 0) v = v + 1024.0;
    else p = 1;
    p = p - 25;
    while (p > 0) begin v = v * 2.0; p--; end
    while (p < 0) begin v = v / 2.0; p++; end
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    real        a;
    int         e;
    logic       s;
    logic [9:0] m;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 15;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = 10'($rtoi((a - 1.0) * 1024.0));
    return {s, 5'(e), m};
  endfunction

  // External adder: ADD_LAT register stages, exact for the small integers used here
  always @(posedge clk) begin
    pipe[0] <= r2h(add_mode ? h2r(add_a) - h2r(add_b) : h2r(add_a) + h2r(add_b));
    for (int i = 1; i < ADD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign add_res = force_en ? force_val : pipe[ADD_LAT-1];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic send_elem(input logic [15:0] d, input logic last, input logic mode);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (t >= 200) chk("rdy_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = d; in_last = last; in_mode = mode;
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic get_out(input string tag, input logic [15:0] ed, input int ec, input int hold);
    int t;
    t = 0;
    out_ready = 1'b0;
    while (!out_valid && t < 2000) begin @(posedge clk); #1; t++; end
    ov_cyc = cyc;
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(ed));
    chk({tag, "_cnt"}, 32'(out_count), 32'(ec));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_data"}, 32'(out_data), 32'(ed));
      chk({tag, "_hold_cnt"}, 32'(out_count), 32'(ec));
      chk({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_post_vld"}, 32'(out_valid), 32'd0);
    chk({tag, "_post_data"}, 32'(out_data), 32'd0);
    chk({tag, "_post_rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int          n, v, lowcnt, gc;
    logic        md, mi;
    real         sum;
    logic [15:0] gd;

    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; in_mode = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_rdy", 32'(in_ready), 32'd0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_adda", 32'(add_a), 32'd0);
    chk("rst_addb", 32'(add_b), 32'd0);
    chk("rst_cnt", 32'(out_count), 32'd0);
    #12 rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_rdy", 32'(in_ready), 32'd1);

    // add packet with operand and latency checks
    send_elem(16'h3C00, 1'b0, 1'b0);
    n = acc_cyc;
    chk("add_a0", 32'(add_a), 32'h0000);
    chk("add_b0", 32'(add_b), 32'h3C00);
    chk("add_rdy0", 32'(in_ready), 32'd0);
    send_elem(16'h4000, 1'b1, 1'b0);
    chk("add_per", 32'(acc_cyc - n), 32'(ADD_LAT + 2));
    chk("add_a1", 32'(add_a), 32'h3C00);
    chk("add_b1", 32'(add_b), 32'h4000);
    get_out("add", 16'h4200, 2, 0);
    chk("add_lat", 32'(ov_cyc - n), 32'(2 * (ADD_LAT + 2) - 1));

    // subtract packet; mode on the second element must be ignored
    send_elem(16'h3C00, 1'b0, 1'b1);
    chk("sub_mode0", 32'(add_mode), 32'd1);
    send_elem(16'h4000, 1'b1, 1'b0);
    chk("sub_mode1", 32'(add_mode), 32'd1);
    get_out("sub", 16'hC200, 2, 0);

    // single element, downstream always ready
    out_ready = 1'b1;
    send_elem(16'h3800, 1'b1, 1'b0);
    lowcnt = 0; gd = 16'hFFFF; gc = -1;
    while (!in_ready && lowcnt < 50) begin
      if (out_valid) begin gd = out_data; gc = int'(out_count); end
      lowcnt++;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    chk("one_low", 32'(lowcnt), 32'(ADD_LAT + 2));
    chk("one_data", 32'(gd), 32'h3800);
    chk("one_cnt", 32'(gc), 32'd1);

    // backpressure: five stalled cycles in OUT
    send_elem(16'h4400, 1'b1, 1'b0);
    get_out("bp", 16'h4400, 1, 5);

    // clr while the second of three elements is in flight
    send_elem(16'h4400, 1'b0, 1'b1);
    send_elem(16'h4400, 1'b0, 1'b0);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_rdy", 32'(in_ready), 32'd1);
    chk("clr_addb", 32'(add_b), 32'd0);
    chk("clr_mode", 32'(add_mode), 32'd0);
    chk("clr_adda", 32'(add_a), 32'd0);
    for (int i = 0; i < ADD_LAT + 3; i++) begin
      @(posedge clk); #1;
      chk("clr_novld", 32'(out_valid), 32'd0);
    end
    send_elem(16'h4200, 1'b1, 1'b0);
    get_out("clr_new", 16'h4200, 1, 0);

    // asynchronous reset mid-WAIT
    send_elem(16'h4400, 1'b0, 1'b1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("arst_rdy", 32'(in_ready), 32'd0);
    chk("arst_adda", 32'(add_a), 32'd0);
    chk("arst_addb", 32'(add_b), 32'd0);
    chk("arst_mode", 32'(add_mode), 32'd0);
    chk("arst_vld", 32'(out_valid), 32'd0);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("arst_rel_rdy", 32'(in_ready), 32'd1);
    chk("arst_rel_vld", 32'(out_valid), 32'd0);
    send_elem(16'h4200, 1'b1, 1'b0);
    get_out("arst_new", 16'h4200, 1, 0);

    // adder result forwarded verbatim (NaN and -Inf)
    force_en = 1'b1; force_val = 16'h7E01;
    send_elem(16'h3C00, 1'b1, 1'b0);
    get_out("nan", 16'h7E01, 1, 0);
    force_val = 16'hFC00;
    send_elem(16'h3C00, 1'b1, 1'b1);
    get_out("ninf", 16'hFC00, 1, 0);
    force_en = 1'b0;

    // randomized packets against the real-valued sum
    for (int p = 0; p < 20; p++) begin
      n   = $urandom_range(1, 6);
      md  = 1'($urandom_range(0, 1));
      sum = 0.0;
      for (int k = 0; k < n; k++) begin
        v   = int'($urandom_range(0, 16)) - 8;
        sum = md ? sum - real'(v) : sum + real'(v);
        mi  = (k == 0) ? md : 1'($urandom_range(0, 1));
        send_elem(r2h(real'(v)), k == n - 1, mi);
      end
      get_out("rnd", r2h(sum), n, $urandom_range(0, 3));
    end

    // element count saturates rather than wrapping
    n = (1 << CNT_W) + 2;
    for (int k = 0; k < n; k++) send_elem(16'h3C00, k == n - 1, 1'b0);
    get_out("sat", r2h(real'(n)), (1 << CNT_W) - 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
